// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter in front of the shared register-file read mux.
// Cycle N: combinational grant. Edge N: winner's address drives the mux
// select. Edge N+1: mux output is captured and returned with a one-hot valid.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]         mux_select,
  input  logic [DATA_W-1:0]         mux_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so pointer + offset cannot overflow before the wrap.
  localparam int CAND_W = PTR_W + 1;

  // Requester index -> one-hot vector.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == PTR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Next round-robin start position, wrapping NUM_REQ-1 -> 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] nxt;
    if (idx == PTR_W'(NUM_REQ - 1)) nxt = '0;
    else                            nxt = idx + PTR_W'(1);
    return nxt;
  endfunction

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [CAND_W-1:0]  cand;
  logic               grant_en;
  logic [ADDR_W-1:0]  win_addr;

  logic [ADDR_W-1:0]  sel_p1_q, sel_p1_d;
  logic               vld_p1_q, vld_p1_d;
  logic [PTR_W-1:0]   id_p1_q, id_p1_d;

  logic [NUM_REQ-1:0] vld_p2_q, vld_p2_d;
  logic [DATA_W-1:0]  data_p2_q, data_p2_d;

  // Search requesters starting at the pointer for the first active one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + CAND_W'(k);
      if (cand >= CAND_W'(NUM_REQ)) cand = cand - CAND_W'(NUM_REQ);
      if (!win_found && req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Grant is suppressed during reset and stall; otherwise one-hot of the winner.
  always_comb begin
    grant_en = rst_n & ~stall & win_found;
    grant    = grant_en ? onehot(win_idx) : '0;
  end

  // Pick the winner's register index out of the packed address bus.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) win_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // ---- stage 0 -> stage 1: pointer advance and mux select capture ----
  always_comb begin
    ptr_d    = ptr_q;
    sel_p1_d = sel_p1_q;
    id_p1_d  = id_p1_q;
    vld_p1_d = grant_en;
    if (grant_en) begin
      ptr_d    = ptr_inc(win_idx);
      sel_p1_d = win_addr;
      id_p1_d  = win_idx;
    end
  end

  // ---- stage 1 -> stage 2: capture mux output for the stage-1 owner ----
  always_comb begin
    vld_p2_d  = '0;
    data_p2_d = data_p2_q;
    if (vld_p1_q) begin
      vld_p2_d  = onehot(id_p1_q);
      data_p2_d = mux_data;
    end
  end

  // State registers; reset drops any read in flight and restarts priority at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      sel_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      id_p1_q   <= '0;
      vld_p2_q  <= '0;
      data_p2_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      sel_p1_q  <= sel_p1_d;
      vld_p1_q  <= vld_p1_d;
      id_p1_q   <= id_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
    end
  end

  assign mux_select = sel_p1_q;
  assign rsp_valid  = vld_p2_q;
  assign rsp_data   = data_p2_q;
  assign busy       = vld_p1_q | (|vld_p2_q);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: grant vectors from a table, responses
// tracked by a scoreboard fed from observed grants and a model of the mux.
module tb_regfile_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;

  logic                      clk;
  logic                      rst_n;
  logic                      stall;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        grant;
  logic [ADDR_W-1:0]         mux_select;
  logic [DATA_W-1:0]         mux_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [NUM_REQ-1:0] id;
    logic [DATA_W-1:0]  data;
    int                 due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [NUM_REQ-1:0]        req;
    logic                      stall;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        exp_grant;
  } vec_t;
  vec_t vecs[$];

  regfile_read_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req(req), .req_addr(req_addr),
    .grant(grant), .mux_select(mux_select), .mux_data(mux_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // Register-file read mux model.
  function automatic logic [DATA_W-1:0] mux_fn(input logic [ADDR_W-1:0] sel);
    logic [DATA_W-1:0] v;
    if (sel == 4'hA) v = 16'h1234;
    else             v = {sel, ~sel, sel ^ 4'h5, sel + 4'h7};
    return v;
  endfunction

  assign mux_data = mux_fn(mux_select);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: each observed grant is expected back two cycles later.
  always @(negedge clk) begin : mon
    exp_t e;
    logic exp_busy;
    if (!rst_n) begin
      sb.delete();
    end else begin
      exp_busy = 1'b0;
      foreach (sb[i]) if (sb[i].due == cyc || sb[i].due == cyc + 1) exp_busy = 1'b1;
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, e.id});
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
      end else begin
        chk("rsp_idle", {28'd0, rsp_valid}, 32'd0);
      end
      if (grant != '0) begin
        chk("grant_onehot", {31'd0, $onehot(grant)}, 32'd1);
        e.id   = grant;
        e.data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant[i]) e.data = mux_fn(req_addr[i*ADDR_W +: ADDR_W]);
        end
        e.due = cyc + 2;
        sb.push_back(e);
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic s, input logic [15:0] a);
    @(posedge clk);
    #1;
    req      = r;
    stall    = s;
    req_addr = a;
  endtask

  task automatic add_vec(input logic [3:0] r, input logic s, input logic [15:0] a,
                         input logic [3:0] g);
    vec_t v;
    v.req = r; v.stall = s; v.addr = a; v.exp_grant = g;
    vecs.push_back(v);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst_n    = 1'b1;
    stall    = 1'b0;
    req      = '0;
    req_addr = '0;

    // Round-robin / wrap / stall / same-address / held-requester vectors.
    add_vec(4'b1111, 0, 16'h4321, 4'b0010);
    add_vec(4'b1111, 0, 16'h4321, 4'b0100);
    add_vec(4'b1111, 0, 16'h4321, 4'b1000);
    add_vec(4'b1111, 0, 16'h4321, 4'b0001);
    add_vec(4'b1111, 0, 16'h4321, 4'b0010);
    add_vec(4'b1111, 0, 16'h4321, 4'b0100);
    add_vec(4'b1111, 0, 16'h4321, 4'b1000);
    add_vec(4'b0100, 0, 16'h4321, 4'b0100);
    add_vec(4'b0001, 0, 16'h4321, 4'b0001);
    add_vec(4'b1000, 0, 16'h4321, 4'b1000);
    add_vec(4'b1001, 0, 16'h4321, 4'b0001);
    add_vec(4'b1001, 0, 16'h4321, 4'b1000);
    add_vec(4'b0100, 0, 16'h4321, 4'b0100);
    add_vec(4'b0010, 1, 16'h4321, 4'b0000);
    add_vec(4'b0010, 1, 16'h4321, 4'b0000);
    add_vec(4'b0010, 1, 16'h4321, 4'b0000);
    add_vec(4'b0010, 0, 16'h4321, 4'b0010);
    add_vec(4'b1111, 1, 16'h4321, 4'b0000);
    add_vec(4'b1111, 0, 16'h4321, 4'b0100);
    add_vec(4'b1111, 0, 16'h4321, 4'b1000);
    add_vec(4'b0011, 0, 16'h5555, 4'b0001);
    add_vec(4'b0011, 0, 16'h5555, 4'b0010);
    add_vec(4'b0100, 0, 16'h4321, 4'b0100);
    add_vec(4'b0100, 0, 16'h4321, 4'b0100);
    add_vec(4'b0100, 0, 16'h4321, 4'b0100);
    add_vec(4'b0000, 0, 16'h4321, 4'b0000);
    add_vec(4'b0000, 0, 16'h4321, 4'b0000);

    // Reset held with all requests active.
    #2;
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (2) begin
      @(negedge clk);
      chk("rst_grant", {28'd0, grant}, 32'd0);
      chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
      chk("rst_mux_select", {28'd0, mux_select}, 32'd0);
      chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    req_addr = 16'h4321;
    @(negedge clk);
    chk("release_grant", {28'd0, grant}, 32'h1);

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].stall, vecs[i].addr);
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), {28'd0, grant}, {28'd0, vecs[i].exp_grant});
    end

    // Single read with explicit per-cycle timing.
    drive(4'b0100, 0, 16'h0A00);
    @(negedge clk);
    chk("single_grant", {28'd0, grant}, 32'h4);
    drive(4'b0000, 0, 16'h0A00);
    @(negedge clk);
    chk("single_mux_select", {28'd0, mux_select}, 32'hA);
    chk("single_busy", {31'd0, busy}, 32'd1);
    drive(4'b0000, 0, 16'h0A00);
    @(negedge clk);
    chk("single_rsp_valid", {28'd0, rsp_valid}, 32'h4);
    chk("single_rsp_data", {16'd0, rsp_data}, 32'h1234);

    // Reset pulsed while a read is in flight; pointer advanced to 1 beforehand.
    drive(4'b0001, 0, 16'h4321);
    @(negedge clk);
    chk("mid_grant", {28'd0, grant}, 32'h1);
    @(posedge clk);
    #1;
    req   = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {28'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b0011;
    @(negedge clk);
    chk("mid_post_valid", {28'd0, rsp_valid}, 32'd0);
    chk("mid_post_busy", {31'd0, busy}, 32'd0);
    chk("mid_post_grant", {28'd0, grant}, 32'h1);
    drive(4'b0000, 0, 16'h4321);

    // Let outstanding reads retire, then everything granted must have returned.
    repeat (6) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Shares the single 16:1 x 16-bit register-file read mux among NUM_REQ requesters, e.g. fetch/decode operand A, operand B, debug port and interrupt save logic.
- Arbitrates round-robin and drives the mux select from a register.
- Captures the mux output and returns it to the winning requester with a one-hot valid.
- Sits between the mux and the pipeline control; fully pipelined, one grant per cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, register/mux data width.
- ADDR_W, 4, register index width (mux select width).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  pipeline stall; when high, no new grants are issued.
- req  input  NUM_REQ  per-requester read request, level, held until granted.
- req_addr  input  NUM_REQ*ADDR_W  register index per requester; requester i uses bits [i*ADDR_W +: ADDR_W].
- grant  output  NUM_REQ  combinational one-hot grant, same cycle as the winning req.
- mux_select  output  ADDR_W  registered select to the read mux.
- mux_data  input  DATA_W  combinational output of the read mux.
- rsp_valid  output  NUM_REQ  registered one-hot, one-cycle pulse per completed read.
- rsp_data  output  DATA_W  registered read data, valid when rsp_valid != 0.
- busy  output  1  high while any read is in flight (stage 1 or stage 2 valid).

Behaviour:
- Reset (rst_n low, asynchronous):
  - mux_select=0, rsp_valid=0, rsp_data=0, busy=0.
  - Round-robin pointer=0; both pipeline valid bits cleared.
  - grant=0 while rst_n is low.
- Arbitration (cycle N, combinational):
  - If stall=0 and req!=0, grant exactly one requester: the first set req bit at or after the pointer, wrapping NUM_REQ-1 -> 0.
  - Otherwise grant=0.
  - Requester drops req on the edge after it sees grant; a req held high is a new request.
- Pointer:
  - On a grant edge, pointer <= winner+1 (mod NUM_REQ).
  - Pointer is unchanged when there is no grant or stall=1.
- Stage 1 (edge ending cycle N):
  - On grant: mux_select <= req_addr of winner, s1_valid <= 1, s1_id <= winner index.
  - Without grant: s1_valid <= 0; mux_select holds its last value.
- Stage 2 (edge ending cycle N+1):
  - If s1_valid: rsp_data <= mux_data, rsp_valid <= onehot(s1_id).
  - Otherwise rsp_valid <= 0 and rsp_data holds.
- Latency and throughput:
  - grant in cycle N -> rsp_valid/rsp_data visible in cycle N+2.
  - Throughput is one read per cycle; back-to-back grants pipeline with no bubble.
- stall:
  - Blocks only new grants.
  - In-flight stage 1/2 reads still complete; responses are not held back by stall.
- busy = s1_valid | (rsp_valid != 0).
- Boundary conditions:
  - Single requester held continuously: granted every cycle.
  - All requesters active: strict rotation 0,1,2,3,0...; no requester waits more than NUM_REQ-1 grants.
  - Pointer wrap: pointer=NUM_REQ-1 with only req[0] set -> grant[0], pointer -> 1.
  - Two requesters with the same address: served serially, identical data.
  - Reset asserted mid-read: in-flight reads are dropped with no rsp_valid pulse. After deassertion the first grant takes priority from requester 0.
  - Out-of-range requester index cannot occur (one-hot encoding).

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> grant=0, rsp_valid=0, mux_select=0, busy=0. Release -> first grant=4'b0001.
- Single read: req[2]=1, addr2=4'hA, mux model returns 16'h1234 for select A.
  - Cycle 0: grant=4'b0100.
  - Cycle 1: mux_select=A.
  - Cycle 2: rsp_valid=4'b0100, rsp_data=16'h1234.
- Round-robin fairness: req=4'b1111 held, addresses 1,2,3,4 -> grants 0001,0010,0100,1000,0001 on consecutive cycles. rsp_data returns the mux values for 1,2,3,4 two cycles after each grant.
- Wrap and pointer: after grant to requester 3, assert only req[0] and req[3] -> grant[0] first, then grant[3].
- Stall: req[1]=1 with stall=1 for 3 cycles -> grant=0 throughout and pointer unchanged. A read granted the cycle before stall still produces rsp_valid 2 cycles after its grant. Dropping stall -> grant[1] the same cycle.
- Reset mid-flight: grant requester 0 at cycle 0, pulse rst_n low in cycle 1 -> no rsp_valid for it, busy=0, pointer=0 after release.
